can_rx: RTL and testbench
=========================

Name: can_rx

Overview:
- Receive side of the CAN controller, paired with the transmitter on the same bus.
- Samples the serial bus once per bit-time, removes stuff bits, checks CRC-15 and frame form, and drives the ACK slot.
- Delivers identifier, RTR, DLC and up to 4 data bytes to the host logic with a one-cycle valid strobe.
- Single clock domain: clk plus a one-cycle sample strobe from the bit-timing logic.

Parameters:
- MAX_BYTES, 4, max data bytes accepted; fixed width of rx_data = 8*MAX_BYTES.
- IDLE_BITS, 11, consecutive recessive bits needed for bus-idle integration.
- CRC_POLY, 15'h4599, CAN CRC-15 polynomial.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- bit_tick  in  1  one-clk pulse at the bit sample point
- rx  in  1  bus level; 1 = recessive
- ack_tx  out  1  bus drive for ACK; 0 only during ACK slot of a good frame, else 1
- rx_id  out  11  received identifier
- rx_rtr  out  1  received RTR bit
- rx_dlc  out  4  received DLC
- rx_data  out  8*MAX_BYTES  received data, right-aligned
- rx_valid  out  1  one-clk pulse: frame accepted
- rx_error  out  1  one-clk pulse: frame aborted
- err_code  out  3  1 stuff, 2 form, 3 crc, 4 dlc, 0 none
- busy  out  1  high from SOF to end of EOF or error

Behaviour:
- Reset values:
  - ack_tx=1; rx_id, rx_rtr, rx_dlc, rx_data = 0.
  - rx_valid, rx_error, err_code, busy = 0.
  - State WAIT_IDLE; all counters 0.
- Timing rule:
  - All state, counters, CRC and shift registers advance only on clk edges with bit_tick=1.
  - rx_valid and rx_error assert on that same edge and clear on the next clk edge.
- States and transitions:
  - WAIT_IDLE: count consecutive 1s; a 0 clears the count; count reaching IDLE_BITS → IDLE.
  - IDLE: rx=0 (SOF) → ID. On SOF: busy=1, err_code=0, CRC=0, stuff count=1, last bit=0.
  - ID: 11 bits, MSB first.
  - RTR, then IDE. IDE=1 (extended frame) → form error.
  - R0: 1 bit, value ignored.
  - DLC: 4 bits, MSB first. DLC>MAX_BYTES → dlc error, evaluated at the last DLC bit.
  - After DLC: RTR=1 or DLC=0 → CRC state; otherwise → DATA for 8*DLC bits.
  - DATA: bits shift into rx_data LSB, MSB first. rx_data is cleared at SOF, so a short frame leaves the upper bits 0.
  - CRC: 15 bits into a separate register.
  - CRC_DEL: must be 1, else form error. On this bit, received CRC != computed CRC → crc error.
  - ACK: ack_tx=0 for this bit-time. It goes low on the CRC_DEL tick and returns to 1 on the ACK tick. The sampled rx is ignored.
  - ACK_DEL: must be 1, else form error.
  - EOF: 7 bits, each must be 1, else form error. At the 7th good bit: latch outputs, pulse rx_valid, busy=0, → IDLE.
- Output latching: rx_id, rx_rtr, rx_dlc, rx_data update only at rx_valid and hold between frames.
- Bit destuffing:
  - Applies from SOF through the last CRC bit.
  - Track the last bit and a run count. After 5 equal bits, the next bit is a stuff bit: not shifted, not CRC'd, not counted toward any field.
  - Stuff bit equal to the previous bit → stuff error.
  - After a stuff bit, the run restarts at 1 with the stuff bit's value.
  - Not applied from CRC_DEL onward.
- CRC: over destuffed bits SOF through the last data bit. Per bit: n = bit ^ crc[14]; crc = crc<<1 (15-bit); if n, crc ^= CRC_POLY.
- Any error: pulse rx_error, set err_code (held until the next SOF), ack_tx=1, busy=0, → WAIT_IDLE. Output data registers are left unchanged. The first detected error wins.
- Reset mid-frame: everything returns to reset values immediately, and the block must re-integrate IDLE_BITS recessive bits.
- A bit_tick in the same cycle as a rst deassertion edge is ignored.

Test Plan:
- Idle integration: reset, then 10 recessive bits followed by a 0 → no SOF accepted. Then 11 recessive bits followed by a good frame → rx_valid=1.
- Good frame: ID=0x123, RTR=0, DLC=4, data=0xDEADBEEF, correct stuffing/CRC → rx_valid one clk after the 7th EOF tick; rx_id=0x123, rx_dlc=4, rx_data=0xDEADBEEF; ack_tx=0 exactly during the ACK bit.
- Stuffing: ID=0x000 (stuffed) decodes correctly. The same frame with six consecutive 0s (stuff bit omitted) → rx_error, err_code=1, no ack.
- CRC: good frame with one CRC bit flipped → rx_error at CRC_DEL, err_code=3, ack_tx stays 1.
- Remote/DLC: RTR=1, DLC=4 → rx_valid, rx_data=0, no data bits consumed. DLC=5 → err_code=4.
- Reset mid-DATA: assert rst at data bit 10 → outputs zero, busy=0; next frame accepted only after 11 recessive bits.

Source files
------------

// File: rtl/can_rx_if.sv
// Signal bundle between the CAN receiver and the rest of the controller:
// the bit-timing strobe and bus level in, ACK drive and received frame out.
interface can_rx_if #(
    parameter int MAX_BYTES = 4
) ();
    logic                   bit_tick;
    logic                   rx;
    logic                   ack_tx;
    logic [10:0]            rx_id;
    logic                   rx_rtr;
    logic [3:0]             rx_dlc;
    logic [8*MAX_BYTES-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_error;
    logic [2:0]             err_code;
    logic                   busy;

    // Receiver side: consumes the sampled bus, produces the frame results
    modport slave (
        input  bit_tick, rx,
        output ack_tx, rx_id, rx_rtr, rx_dlc, rx_data,
        output rx_valid, rx_error, err_code, busy
    );

    // Controller side: supplies the sampled bus, consumes the frame results
    modport master (
        output bit_tick, rx,
        input  ack_tx, rx_id, rx_rtr, rx_dlc, rx_data,
        input  rx_valid, rx_error, err_code, busy
    );
endinterface

// File: rtl/can_rx.sv
// CAN receive path: bus-idle integration, bit destuffing, CRC-15 check,
// frame form checks and ACK slot drive. Standard (11-bit) frames only.
module can_rx #(
    parameter int          MAX_BYTES = 4,
    parameter int          IDLE_BITS = 11,
    parameter logic [14:0] CRC_POLY  = 15'h4599
) (
    input  logic    clk,
    input  logic    rst,
    can_rx_if.slave bus
);
    localparam int DW = 8 * MAX_BYTES;
    localparam int IW = $clog2(IDLE_BITS + 1);

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_STUFF = 3'd1;
    localparam logic [2:0] ERR_FORM  = 3'd2;
    localparam logic [2:0] ERR_CRC   = 3'd3;
    localparam logic [2:0] ERR_DLC   = 3'd4;

    typedef enum logic [3:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_ID,
        S_RTR,
        S_IDE,
        S_R0,
        S_DLC,
        S_DATA,
        S_CRC,
        S_CRC_DEL,
        S_ACK,
        S_ACK_DEL,
        S_EOF
    } state_t;

    state_t          state_q;
    logic            armed_q;
    logic [IW-1:0]   idleCnt_q;
    logic [6:0]      bitCnt_q;
    logic [2:0]      runCnt_q;
    logic            lastBit_q;

    logic [10:0]     id_q;
    logic            rtr_q;
    logic [3:0]      dlc_q;
    logic [DW-1:0]   data_q;
    logic [14:0]     crcRx_q;
    logic [14:0]     crcCalc_q;

    logic            ackTx_q;
    logic [10:0]     rxId_q;
    logic            rxRtr_q;
    logic [3:0]      rxDlc_q;
    logic [DW-1:0]   rxData_q;
    logic            rxValid_q;
    logic            rxError_q;
    logic [2:0]      errCode_q;
    logic            busy_q;

    logic            tick;
    logic            inStuff;
    logic            stuffBit;
    logic [14:0]     crc_d;
    logic [3:0]      dlc_d;
    logic [6:0]      dataLast_d;
    logic [2:0]      err_d;

    // The first tick after reset release is dropped, so armed_q gates it
    assign tick       = bus.bit_tick & armed_q;
    assign inStuff    = state_q inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC};
    assign stuffBit   = inStuff && (runCnt_q == 3'd5);
    assign crc_d      = {crcCalc_q[13:0], 1'b0} ^ ((bus.rx ^ crcCalc_q[14]) ? CRC_POLY : 15'd0);
    assign dlc_d      = {dlc_q[2:0], bus.rx};
    assign dataLast_d = {dlc_q, 3'b000} - 7'd1;

    // Error detection for the bit being sampled; stuff violations take priority
    always_comb begin
        err_d = ERR_NONE;
        if (tick) begin
            if (stuffBit) begin
                if (bus.rx == lastBit_q) begin
                    err_d = ERR_STUFF;
                end
            end else begin
                case (state_q)
                    S_IDE: begin
                        if (bus.rx) begin
                            err_d = ERR_FORM;
                        end
                    end
                    S_DLC: begin
                        if (bitCnt_q == 7'd3 && dlc_d > 4'(MAX_BYTES)) begin
                            err_d = ERR_DLC;
                        end
                    end
                    S_CRC_DEL: begin
                        if (!bus.rx) begin
                            err_d = ERR_FORM;
                        end else if (crcRx_q != crcCalc_q) begin
                            err_d = ERR_CRC;
                        end
                    end
                    S_ACK_DEL, S_EOF: begin
                        if (!bus.rx) begin
                            err_d = ERR_FORM;
                        end
                    end
                    default: err_d = ERR_NONE;
                endcase
            end
        end
    end

    // Frame state machine with destuffing, CRC accumulation and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_WAIT_IDLE;
            armed_q   <= 1'b0;
            idleCnt_q <= '0;
            bitCnt_q  <= '0;
            runCnt_q  <= '0;
            lastBit_q <= 1'b0;
            id_q      <= '0;
            rtr_q     <= 1'b0;
            dlc_q     <= '0;
            data_q    <= '0;
            crcRx_q   <= '0;
            crcCalc_q <= '0;
            ackTx_q   <= 1'b1;
            rxId_q    <= '0;
            rxRtr_q   <= 1'b0;
            rxDlc_q   <= '0;
            rxData_q  <= '0;
            rxValid_q <= 1'b0;
            rxError_q <= 1'b0;
            errCode_q <= ERR_NONE;
            busy_q    <= 1'b0;
        end else begin
            armed_q   <= 1'b1;
            rxValid_q <= 1'b0;
            rxError_q <= 1'b0;
            if (err_d != ERR_NONE) begin
                rxError_q <= 1'b1;
                errCode_q <= err_d;
                ackTx_q   <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= S_WAIT_IDLE;
                idleCnt_q <= '0;
                bitCnt_q  <= '0;
            end else if (tick) begin
                if (stuffBit) begin
                    runCnt_q  <= 3'd1;
                    lastBit_q <= bus.rx;
                end else begin
                    if (inStuff) begin
                        runCnt_q  <= (bus.rx == lastBit_q) ? runCnt_q + 3'd1 : 3'd1;
                        lastBit_q <= bus.rx;
                    end
                    case (state_q)
                        S_WAIT_IDLE: begin
                            if (!bus.rx) begin
                                idleCnt_q <= '0;
                            end else if (idleCnt_q == IW'(IDLE_BITS - 1)) begin
                                idleCnt_q <= '0;
                                state_q   <= S_IDLE;
                            end else begin
                                idleCnt_q <= idleCnt_q + 1'b1;
                            end
                        end
                        S_IDLE: begin
                            if (!bus.rx) begin
                                busy_q    <= 1'b1;
                                errCode_q <= ERR_NONE;
                                crcCalc_q <= '0;
                                runCnt_q  <= 3'd1;
                                lastBit_q <= 1'b0;
                                bitCnt_q  <= '0;
                                id_q      <= '0;
                                rtr_q     <= 1'b0;
                                dlc_q     <= '0;
                                data_q    <= '0;
                                state_q   <= S_ID;
                            end
                        end
                        S_ID: begin
                            id_q      <= {id_q[9:0], bus.rx};
                            crcCalc_q <= crc_d;
                            if (bitCnt_q == 7'd10) begin
                                bitCnt_q <= '0;
                                state_q  <= S_RTR;
                            end else begin
                                bitCnt_q <= bitCnt_q + 7'd1;
                            end
                        end
                        S_RTR: begin
                            rtr_q     <= bus.rx;
                            crcCalc_q <= crc_d;
                            state_q   <= S_IDE;
                        end
                        S_IDE: begin
                            crcCalc_q <= crc_d;
                            state_q   <= S_R0;
                        end
                        S_R0: begin
                            crcCalc_q <= crc_d;
                            bitCnt_q  <= '0;
                            state_q   <= S_DLC;
                        end
                        S_DLC: begin
                            dlc_q     <= dlc_d;
                            crcCalc_q <= crc_d;
                            if (bitCnt_q == 7'd3) begin
                                bitCnt_q <= '0;
                                state_q  <= (rtr_q || dlc_d == 4'd0) ? S_CRC : S_DATA;
                            end else begin
                                bitCnt_q <= bitCnt_q + 7'd1;
                            end
                        end
                        S_DATA: begin
                            data_q    <= {data_q[DW-2:0], bus.rx};
                            crcCalc_q <= crc_d;
                            if (bitCnt_q == dataLast_d) begin
                                bitCnt_q <= '0;
                                state_q  <= S_CRC;
                            end else begin
                                bitCnt_q <= bitCnt_q + 7'd1;
                            end
                        end
                        S_CRC: begin
                            crcRx_q <= {crcRx_q[13:0], bus.rx};
                            if (bitCnt_q == 7'd14) begin
                                bitCnt_q <= '0;
                                state_q  <= S_CRC_DEL;
                            end else begin
                                bitCnt_q <= bitCnt_q + 7'd1;
                            end
                        end
                        S_CRC_DEL: begin
                            ackTx_q <= 1'b0;
                            state_q <= S_ACK;
                        end
                        S_ACK: begin
                            ackTx_q <= 1'b1;
                            state_q <= S_ACK_DEL;
                        end
                        S_ACK_DEL: begin
                            bitCnt_q <= '0;
                            state_q  <= S_EOF;
                        end
                        S_EOF: begin
                            if (bitCnt_q == 7'd6) begin
                                rxId_q    <= id_q;
                                rxRtr_q   <= rtr_q;
                                rxDlc_q   <= dlc_q;
                                rxData_q  <= data_q;
                                rxValid_q <= 1'b1;
                                busy_q    <= 1'b0;
                                bitCnt_q  <= '0;
                                state_q   <= S_IDLE;
                            end else begin
                                bitCnt_q <= bitCnt_q + 7'd1;
                            end
                        end
                        default: begin
                            state_q <= S_WAIT_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.ack_tx   = ackTx_q;
    assign bus.rx_id    = rxId_q;
    assign bus.rx_rtr   = rxRtr_q;
    assign bus.rx_dlc   = rxDlc_q;
    assign bus.rx_data  = rxData_q;
    assign bus.rx_valid = rxValid_q;
    assign bus.rx_error = rxError_q;
    assign bus.err_code = errCode_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_can_rx.sv
// Scoreboard bench for can_rx: an encoder builds stuffed frames with their
// own CRC, expected results are queued per frame and matched by a monitor.
module tb_can_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;

    typedef struct {
        bit          isErr;
        logic [2:0]  code;
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [31:0] data;
    } exp_t;

    exp_t        expQ[$];
    exp_t        e;
    bit          stream[$];
    int          crcDelIdx;
    int          data10Idx;
    int          errors = 0;
    int          checks = 0;
    int          doneCnt = 0;
    int          pushCnt = 0;
    logic [10:0] lastId = '0;
    logic        lastRtr = 1'b0;
    logic [3:0]  lastDlc = '0;
    logic [31:0] lastData = '0;

    can_rx_if #(.MAX_BYTES(4)) bus ();

    can_rx #(
        .MAX_BYTES(4),
        .IDLE_BITS(11),
        .CRC_POLY (15'h4599)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Encode one frame into `stream`: SOF..CRC stuffed, then delimiters and EOF.
    // mode 1 omits the first stuff bit, mode 2 corrupts one CRC bit.
    task automatic buildFrame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] data, input int mode);
        bit          raw[$];
        logic [14:0] crc;
        bit          n;
        bit          last;
        bit          dropped;
        int          run;
        int          nData;
        raw = {};
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nData = rtr ? 0 : 8 * int'(dlc);
        for (int i = nData - 1; i >= 0; i--) raw.push_back(data[i]);
        crc = '0;
        foreach (raw[k]) begin
            n   = raw[k] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (n) crc = crc ^ 15'h4599;
        end
        if (mode == 2) crc[3] = ~crc[3];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        stream    = {};
        run       = 0;
        last      = 1'b0;
        dropped   = 1'b0;
        data10Idx = -1;
        foreach (raw[k]) begin
            if (k == 29) data10Idx = stream.size();
            stream.push_back(raw[k]);
            if (k == 0 || raw[k] != last) run = 1;
            else run++;
            last = raw[k];
            if (run == 5 && k != raw.size() - 1) begin
                if (mode == 1 && !dropped) begin
                    dropped = 1'b1;
                end else begin
                    stream.push_back(~raw[k]);
                    run  = 1;
                    last = ~raw[k];
                end
            end
        end
        crcDelIdx = stream.size();
        for (int i = 0; i < 10; i++) stream.push_back(1'b1);
    endtask

    // One bit-time: present the level, pulse bit_tick, sample the result after the edge
    task automatic driveBit(input bit b, output bit ackObs, output bit busyObs);
        @(negedge clk);
        bus.rx       = b;
        bus.bit_tick = 1'b1;
        @(negedge clk);
        bus.bit_tick = 1'b0;
        ackObs       = bus.ack_tx;
        busyObs      = bus.busy;
        repeat (2) @(negedge clk);
    endtask

    task automatic driveOnes(input int count);
        bit a, b;
        for (int i = 0; i < count; i++) driveBit(1'b1, a, b);
    endtask

    // Drive a whole frame; expCode 0 = accept, else expected error code.
    // mode 3 means the receiver must ignore the frame entirely.
    task automatic applyStimulus(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                                 input logic [63:0] data, input int mode, input logic [2:0] expCode);
        exp_t x;
        bit   a, b;
        bit   busySeen;
        int   ackLowCnt;
        int   ackLowIdx;
        buildFrame(id, rtr, dlc, data, mode);
        if (mode != 3) begin
            x.isErr = (expCode != 3'd0);
            x.code  = expCode;
            x.id    = id;
            x.rtr   = rtr;
            x.dlc   = dlc;
            x.data  = '0;
            if (!rtr) begin
                for (int i = 0; i < 8 * int'(dlc) && i < 32; i++) x.data[i] = data[i];
            end
            expQ.push_back(x);
            pushCnt++;
        end
        busySeen  = 1'b0;
        ackLowCnt = 0;
        ackLowIdx = -1;
        foreach (stream[i]) begin
            driveBit(stream[i], a, b);
            if (!a) begin
                ackLowCnt++;
                ackLowIdx = i;
            end
            if (b) busySeen = 1'b1;
        end
        for (int k = 0; k < 40 && doneCnt < pushCnt; k++) @(negedge clk);
        checkOutput("completion", 64'(doneCnt), 64'(pushCnt));
        if (mode == 3) begin
            checkOutput("ignored_busy", 64'(busySeen), 64'd0);
            checkOutput("ignored_ack", 64'(ackLowCnt), 64'd0);
        end else if (expCode == 3'd0) begin
            checkOutput("ack_low_bits", 64'(ackLowCnt), 64'd1);
            checkOutput("ack_low_pos", 64'(ackLowIdx), 64'(crcDelIdx));
        end else begin
            checkOutput("err_ack_low_bits", 64'(ackLowCnt), 64'd0);
            checkOutput("err_busy_seen", 64'(busySeen), 64'd1);
        end
    endtask

    // Monitor: every valid/error strobe is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && (bus.rx_valid || bus.rx_error)) begin
            doneCnt++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_event", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("event_kind", 64'({bus.rx_valid, bus.rx_error}), e.isErr ? 64'd1 : 64'd2);
                checkOutput("busy_at_end", 64'(bus.busy), 64'd0);
                checkOutput("err_code", 64'(bus.err_code), 64'(e.code));
                if (!e.isErr) begin
                    checkOutput("rx_id", 64'(bus.rx_id), 64'(e.id));
                    checkOutput("rx_rtr", 64'(bus.rx_rtr), 64'(e.rtr));
                    checkOutput("rx_dlc", 64'(bus.rx_dlc), 64'(e.dlc));
                    checkOutput("rx_data", 64'(bus.rx_data), 64'(e.data));
                    lastId   = e.id;
                    lastRtr  = e.rtr;
                    lastDlc  = e.dlc;
                    lastData = e.data;
                end else begin
                    checkOutput("held_id", 64'(bus.rx_id), 64'(lastId));
                    checkOutput("held_rtr", 64'(bus.rx_rtr), 64'(lastRtr));
                    checkOutput("held_dlc", 64'(bus.rx_dlc), 64'(lastDlc));
                    checkOutput("held_data", 64'(bus.rx_data), 64'(lastData));
                end
            end
        end
    end

    // Main sequence
    initial begin
        bit          a, b;
        logic [10:0] rid;
        logic        rrtr;
        logic [3:0]  rdlc;
        logic [63:0] rdata;

        bus.rx       = 1'b1;
        bus.bit_tick = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_ack_tx", 64'(bus.ack_tx), 64'd1);
        checkOutput("reset_rx_id", 64'(bus.rx_id), 64'd0);
        checkOutput("reset_rx_rtr", 64'(bus.rx_rtr), 64'd0);
        checkOutput("reset_rx_dlc", 64'(bus.rx_dlc), 64'd0);
        checkOutput("reset_rx_data", 64'(bus.rx_data), 64'd0);
        checkOutput("reset_rx_valid", 64'(bus.rx_valid), 64'd0);
        checkOutput("reset_rx_error", 64'(bus.rx_error), 64'd0);
        checkOutput("reset_err_code", 64'(bus.err_code), 64'd0);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);

        // Tick coinciding with reset release must not count toward integration
        @(negedge clk);
        bus.rx       = 1'b1;
        bus.bit_tick = 1'b1;
        rst          = 1'b0;
        @(negedge clk);
        bus.bit_tick = 1'b0;
        driveOnes(10);
        driveBit(1'b0, a, b);
        checkOutput("short_idle_no_sof", 64'(b), 64'd0);

        driveOnes(11);
        applyStimulus(11'h123, 1'b0, 4'd4, 64'hDEADBEEF, 0, 3'd0);
        driveOnes(3);
        applyStimulus(11'h000, 1'b0, 4'd1, 64'h00, 0, 3'd0);
        driveOnes(3);
        applyStimulus(11'h000, 1'b0, 4'd1, 64'h00, 1, 3'd1);
        driveOnes(11);
        applyStimulus(11'h123, 1'b0, 4'd4, 64'hDEADBEEF, 2, 3'd3);
        driveOnes(11);
        applyStimulus(11'h2A5, 1'b1, 4'd4, 64'hCAFEF00D, 0, 3'd0);
        driveOnes(3);
        applyStimulus(11'h0AB, 1'b0, 4'd5, 64'h12_3456_789A, 0, 3'd4);
        driveOnes(11);
        applyStimulus(11'h7FF, 1'b0, 4'd2, 64'hFFFF, 0, 3'd0);
        driveOnes(3);
        applyStimulus(11'h555, 1'b0, 4'd0, 64'h0, 0, 3'd0);

        for (int r = 0; r < 4; r++) begin
            driveOnes(3);
            rid   = 11'($urandom_range(0, 2047));
            rrtr  = ($urandom_range(0, 3) == 0);
            rdlc  = 4'($urandom_range(0, 4));
            rdata = {32'h0, $urandom};
            applyStimulus(rid, rrtr, rdlc, rdata, 0, 3'd0);
        end

        // Reset in the middle of the data field
        driveOnes(3);
        buildFrame(11'h3C1, 1'b0, 4'd4, 64'h89ABCDEF, 0);
        for (int i = 0; i < data10Idx; i++) driveBit(stream[i], a, b);
        @(negedge clk);
        rst      = 1'b1;
        lastId   = '0;
        lastRtr  = 1'b0;
        lastDlc  = '0;
        lastData = '0;
        @(negedge clk);
        checkOutput("midrst_rx_id", 64'(bus.rx_id), 64'd0);
        checkOutput("midrst_rx_dlc", 64'(bus.rx_dlc), 64'd0);
        checkOutput("midrst_rx_data", 64'(bus.rx_data), 64'd0);
        checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
        checkOutput("midrst_ack_tx", 64'(bus.ack_tx), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        driveOnes(10);
        applyStimulus(11'h3C1, 1'b0, 4'd4, 64'h89ABCDEF, 3, 3'd0);
        driveOnes(11);
        applyStimulus(11'h3C1, 1'b0, 4'd4, 64'h89ABCDEF, 0, 3'd0);

        repeat (10) @(negedge clk);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
